// File: rtl/image_pkg.sv
// Shared image geometry and reader-side types, used by the processed-image
// memory, its writer and the streaming reader.
package image_pkg;

  localparam int IMG_WIDTH  = 390;
  localparam int IMG_HEIGHT = 390;
  localparam int IMG_BYTES  = IMG_WIDTH * IMG_HEIGHT;
  localparam int IMG_AW     = 18;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } reader_state_t;

  // One buffered output beat: pixel byte plus its raster position flags.
  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eol;
    logic       eof;
  } pixel_t;

endpackage

// File: rtl/reader_fifo2.sv
// Two-entry FIFO that soaks up the one-cycle memory read latency.
// Simultaneous push and pop leave the count unchanged and preserve order.
module reader_fifo2 #(
  parameter int W = 11
) (
  input  logic         CLK,
  input  logic         clear_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         pop_ok;

  assign pop_ok = pop && (count != 2'd0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (!clear_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push)   wr_ptr <= ~wr_ptr;
      if (pop_ok) rd_ptr <= ~rd_ptr;
      case ({push, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only; validity is tracked by count.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/image_procesada_reader.sv
// Streams the processed image from its byte memory in raster order over a
// valid/ready byte stream, with start/end-of-frame and end-of-line flags.
module image_procesada_reader
  import image_pkg::*;
#(
  parameter int DEPTH = IMG_BYTES,
  parameter int WIDTH = IMG_WIDTH,
  parameter int AW    = IMG_AW
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          start,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sof,
  output logic          out_eol,
  output logic          out_eof,
  output logic          busy,
  output logic          done
);

  localparam int            CW        = $clog2(WIDTH + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(WIDTH - 1);

  reader_state_t state, state_next;
  logic [CW-1:0] col;
  logic          vld_p1;
  logic          sof_p1, eol_p1, eof_p1;
  logic [1:0]    count;
  logic [2:0]    occ;
  logic          pop;
  logic          last_issue;
  pixel_t        head;
  pixel_t        tail;

  assign pop        = out_valid && out_ready;
  assign occ        = {1'b0, count} + {2'b00, vld_p1};
  assign mem_re     = (state == STREAM) && (occ < (3'd2 + {2'b00, pop}));
  assign last_issue = mem_re && (mem_addr == LAST_ADDR);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = STREAM;
      STREAM:  if (last_issue) state_next = DRAIN;
      DRAIN:   if (pop && head.eof) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= IDLE;
      mem_addr <= '0;
      col      <= '0;
      vld_p1   <= 1'b0;
    end else begin
      state  <= state_next;
      vld_p1 <= mem_re;
      if (state == IDLE && start) begin
        mem_addr <= '0;
        col      <= '0;
      end else if (mem_re) begin
        if (!last_issue) mem_addr <= mem_addr + AW'(1);
        col <= (col == LAST_COL) ? '0 : col + CW'(1);
      end
    end
  end

  // Stage p1: position flags ride alongside the read that is in flight.
  always_ff @(posedge CLK) begin
    if (mem_re) begin
      sof_p1 <= (mem_addr == '0);
      eol_p1 <= (col == LAST_COL);
      eof_p1 <= (mem_addr == LAST_ADDR);
    end
  end

  assign tail = {mem_rd, sof_p1, eol_p1, eof_p1};

  reader_fifo2 #(
    .W($bits(pixel_t))
  ) u_fifo (
    .CLK     (CLK),
    .clear_n (RST_N),
    .push    (vld_p1),
    .pop     (pop),
    .din     (tail),
    .head    (head),
    .count   (count)
  );

  assign out_valid = (count != 2'd0);
  assign out_data  = out_valid ? head.data : 8'h00;
  assign out_sof   = out_valid && head.sof;
  assign out_eol   = out_valid && head.eol;
  assign out_eof   = out_valid && head.eof;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_image_procesada_reader.sv
// Bench for image_procesada_reader on a 12-byte, 4-pixel-wide image backed by
// a behavioural memory holding byte[i] = i + 0x10.
module tb_image_procesada_reader;

  localparam int DEPTH = 12;
  localparam int WIDTH = 4;
  localparam int AW    = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rd = 8'h00;
  logic [7:0]    out_data;
  logic          out_valid, out_sof, out_eol, out_eof, busy, done;

  logic [7:0] mem_img [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bit          mon_on = 1'b0;
  int          xfer_cnt, issued, done_cnt, first_valid, done_cyc, eof_cyc;
  bit          prev_stall;
  logic [10:0] prev_head;
  logic [18:0] outs;
  logic        s_busy, s_re, s_done;
  logic [AW-1:0] s_addr;

  image_procesada_reader #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .start     (start),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .out_eof   (out_eof),
    .busy      (busy),
    .done      (done)
  );

  always #5 CLK = ~CLK;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_img[i] = 8'(i + 'h10);
  end

  // Garbage on the read bus whenever no read was issued.
  always @(posedge CLK) begin
    if (mem_re && int'(mem_addr) < DEPTH) mem_rd <= mem_img[int'(mem_addr)];
    else                                  mem_rd <= 8'($urandom);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no summary expected one");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference beat for raster index i: byte from the image, flags from position.
  function automatic logic [10:0] exp_pix(input int i);
    logic sof, eol, eof;
    sof = (i == 0);
    eol = ((i % WIDTH) == WIDTH - 1);
    eof = (i == DEPTH - 1);
    return {mem_img[i], sof, eol, eof};
  endfunction

  task automatic tick();
    bit xfer;
    int outstanding;
    @(negedge CLK);
    cyc++;
    outs   = {mem_re, mem_addr, out_data, out_valid, out_sof, out_eol, out_eof, busy, done};
    s_busy = busy;
    s_re   = mem_re;
    s_done = done;
    s_addr = mem_addr;
    if (mon_on) begin
      xfer = out_valid && out_ready;
      outstanding = issued - xfer_cnt;
      if (prev_stall)
        chk("stall_hold", {out_valid, out_data, out_sof, out_eol, out_eof}, {1'b1, prev_head});
      if (mem_re) begin
        chk("issue_room", (outstanding < 2 + int'(xfer)) ? 1 : 0, 1);
        chk("issue_addr", 32'(mem_addr), issued);
        issued++;
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (xfer) begin
        if (xfer_cnt < DEPTH)
          chk("xfer_beat", {out_data, out_sof, out_eol, out_eof}, exp_pix(xfer_cnt));
        else
          chk("xfer_extra", xfer_cnt, DEPTH - 1);
        if (out_eof) eof_cyc = cyc;
        xfer_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_head  = {out_data, out_sof, out_eol, out_eof};
    end
    @(posedge CLK);
    #1;
  endtask

  // mode 0: ready=1, 1: random ready, 2: 10-cycle stall at first valid,
  // 3: start re-pulsed mid-frame and in DONE, 4: stop after 5 transfers.
  task automatic run_frame(input int mode, output int c0);
    int rel_cyc;
    mon_on = 1'b1;
    xfer_cnt = 0; issued = 0; done_cnt = 0;
    first_valid = -1; done_cyc = -1; eof_cyc = -1;
    prev_stall = 1'b0;
    rel_cyc = -1;
    out_ready = (mode != 2);
    start = 1'b1;
    tick();
    c0 = cyc;
    start = 1'b0;
    while (cyc - c0 < 400) begin
      if (mode == 4 && xfer_cnt == 5) break;
      if (done_cnt > 0 && cyc >= done_cyc + 4) break;
      case (mode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: begin
          if (first_valid >= 0 && cyc + 1 >= first_valid + 10 && !out_ready) begin
            chk("stall_reads", issued, 2);
            out_ready = 1'b1;
            rel_cyc = cyc + 1;
          end
        end
        3: begin
          out_ready = 1'b1;
          start = (cyc + 1 == c0 + 5) || (cyc + 1 == c0 + 6) || (cyc + 1 == c0 + 3 + DEPTH);
        end
        default: out_ready = 1'b1;
      endcase
      tick();
      if (mode == 0 && cyc == c0 + 1)
        chk("k1_busy_re_addr", {s_busy, s_re, 28'(s_addr)}, {1'b1, 1'b1, 28'h0});
      if (mode == 0 && cyc == c0 + DEPTH + 4)
        chk("idle_after_done", {s_busy, s_done, s_re}, 3'b000);
    end
    start = 1'b0;
    if (mode != 4) begin
      chk("frame_timeout", (done_cnt > 0) ? 1 : 0, 1);
      chk("xfer_count", xfer_cnt, DEPTH);
      chk("done_count", done_cnt, 1);
      chk("issue_count", issued, DEPTH);
    end
    if (mode == 0) begin
      chk("first_valid_lat", first_valid - c0, 3);
      chk("eof_lat", eof_cyc - c0, 2 + DEPTH);
      chk("done_lat", done_cyc - c0, 3 + DEPTH);
    end
    if (mode == 2) chk("release_b2b", eof_cyc - rel_cyc, DEPTH - 1);
  endtask

  initial begin
    int c0;
    RST_N = 1'b0;
    repeat (3) tick();
    RST_N = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_zero", 32'(outs), 0);
    end

    run_frame(0, c0);
    run_frame(1, c0);
    run_frame(1, c0);
    run_frame(2, c0);
    run_frame(3, c0);

    run_frame(4, c0);
    mon_on = 1'b0;
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_reset_zero", 32'(outs), 0);
    end
    run_frame(0, c0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/image_procesada_reader.md
# image_procesada_reader

Streams the processed image out of the processed-image byte memory, in raster order, over a valid/ready byte stream. It sits on the read port of that memory and feeds the downstream consumer (display/UART/export path). It drives the memory's synchronous read address and absorbs the memory's one-cycle read latency with a 2-entry buffer. This sustains one byte per cycle under continuous `out_ready` and never drops or duplicates bytes under backpressure.

## Interface
Parameters:
- `DEPTH`, 152100: image size in bytes (390×390, 8-bit pixels).
- `WIDTH`, 390: pixels per line, used for end-of-line marking.
- `AW`, 18: address width; must satisfy 2^AW ≥ DEPTH.

Ports:
- `CLK` in 1: single clock, all logic on the rising edge.
- `RST_N` in 1: synchronous, active-low reset.
- `start` in 1: request one full-frame readout; sampled only in IDLE.
- `mem_re` out 1: memory read enable.
- `mem_addr` out AW: memory read address. Data appears on `mem_rd` the cycle after `mem_re`.
- `mem_rd` in 8: memory read data.
- `out_data` out 8: pixel byte.
- `out_valid` out 1: `out_data` and the flags are valid.
- `out_ready` in 1: consumer accepts. A transfer occurs on an edge with `out_valid && out_ready`.
- `out_sof` out 1: the current byte is address 0.
- `out_eol` out 1: the current byte is the last pixel of a line.
- `out_eof` out 1: the current byte is address DEPTH-1.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse after the final transfer.

## Operation
- FSM states and transitions:
  - IDLE → STREAM on `start`.
  - STREAM → DRAIN once read address DEPTH-1 has been issued.
  - DRAIN → DONE when the last byte has transferred.
  - DONE → IDLE unconditionally after 1 cycle. `done` is high in DONE.
- Read issue:
  - In STREAM, `mem_re` = 1 when (buffered + in_flight − pop_this_cycle) < 2.
  - `mem_addr` increments by 1 after each issued read, from 0 to DEPTH-1.
  - `mem_re` = 0 in all other states; `mem_addr` holds its value.
- Capture: the byte read in cycle n is written into the 2-entry FIFO at the end of cycle n+1. The FIFO never overflows, by the issue rule.
- Output: `out_valid` = FIFO not empty. `out_data` and the flags come from the FIFO head and are held stable while `out_valid && !out_ready`.
- Flags:
  - Stored per entry alongside the byte.
  - `out_sof` at address 0 and `out_eof` at address DEPTH-1.
  - `out_eol` when column = WIDTH-1. The column counter wraps at WIDTH and is independent of the address, so no divider is needed.
- `start` while busy or in DONE is ignored. A frame is always read completely.
- `mem_rd` is ignored when no read is in flight.

## Timing
- Reset (`RST_N` = 0 at an edge) forces all of the following, including mid-frame:
  - state IDLE, FIFO emptied, in-flight cleared, column counter 0;
  - outputs `mem_re`, `mem_addr`, `out_data`, `out_valid`, `out_sof`, `out_eol`, `out_eof`, `busy`, `done` all 0.
  - No partial frame resumes after reset.
- `start` = 1 at edge k:
  - `busy` and `mem_re` = 1 with `mem_addr` = 0 during cycle k+1;
  - first `out_valid` during cycle k+3.
- With `out_ready` held at 1, one transfer per cycle:
  - last transfer (`out_eof`) in cycle k+2+DEPTH;
  - `done` in cycle k+3+DEPTH;
  - `busy` = 0 and the block is back in IDLE from cycle k+4+DEPTH. A new `start` is accepted there.
- Backpressure: with `out_ready` = 0, at most 2 bytes are buffered plus 0 in flight. Issue resumes in the same cycle `out_ready` returns, and throughput returns to 1/cycle with no bubble beyond the memory latency.
- Simultaneous pop and capture in the same cycle: count unchanged, order preserved.

## Structure
- Package `image_pkg`: `IMG_WIDTH` = 390, `IMG_HEIGHT` = 390, `IMG_BYTES` = 152100, `IMG_AW` = 18, and the reader state enum (IDLE, STREAM, DRAIN, DONE). It is shared with the processed-image memory and the writer side.
- Sub-module `reader_fifo2`: 2-entry FIFO with 11-bit payload (8-bit data + 3 flags), push/pop/count, synchronous active-low clear.
- The top level holds the FSM, address and column counters, in-flight flag and issue logic.

## Test plan
Run with `DEPTH` = 12, `WIDTH` = 4, and a behavioral memory preloaded with byte[i] = i+0x10.
- Reset then idle, `start` = 0 for 20 cycles → all outputs 0 and no `mem_re`.
- `start` pulse at edge k, `out_ready` = 1 → `out_valid` from k+3. Bytes 0x10..0x1B on consecutive cycles. `out_sof` on 0x10, `out_eol` on 0x13/0x17/0x1B, `out_eof` on 0x1B, `done` at k+15, `busy` low at k+16.
- `out_ready` toggled randomly (seeded) → exactly 12 transfers, in order, with no duplicates. `out_data` is stable while stalled, and `mem_re` never fires with 2 buffered.
- `out_ready` = 0 for 10 cycles after the first `out_valid` → exactly 2 reads issued, then none. On release, 0x10, 0x11, 0x12… follow back-to-back.
- `start` re-pulsed mid-frame and during DONE → ignored; a single 12-byte frame and one `done`.
- `RST_N` asserted after the 5th transfer → next cycle all outputs 0. A fresh `start` then yields a full frame from 0x10 with `out_sof` on it.
